// File: rtl/spu_regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : spu_rf_pkg
//  Purpose  : Shared constants and state encoding for the SPU multi-ported
//             register file.
//  Contents : QUADWORD, REG_ADDR_WIDTH and REG_COUNT constants.
//             rf_state_t clear/ready state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package spu_rf_pkg;

  localparam int QUADWORD       = 128;
  localparam int REG_ADDR_WIDTH = 7;
  localparam int REG_COUNT      = 128;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

endpackage
`default_nettype wire

// File: rtl/spu_regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module   : spu_regfile_mp_if
//  Purpose  : Bundles the read ports, write ports and status outputs of the
//             SPU multi-ported register file.
//  Ports    : rd_addr, wr_en, wr_addr, wr_data    driven by issue/writeback
//             rd_data, init_busy, wr_conflict     driven by the register file
//  Modports : master = issue/writeback side, slave = register file
//  Revision : 1.0 - initial release
// ============================================================================
interface spu_regfile_mp_if
  import spu_rf_pkg::*;
#(
  parameter int DATA_W = QUADWORD,
  parameter int DEPTH  = REG_COUNT,
  parameter int AW     = $clog2(DEPTH),
  parameter int N_RD   = 5,
  parameter int N_WR   = 2
);

  logic [N_RD-1:0][AW-1:0]     rd_addr;
  logic [N_RD-1:0][DATA_W-1:0] rd_data;
  logic [N_WR-1:0]             wr_en;
  logic [N_WR-1:0][AW-1:0]     wr_addr;
  logic [N_WR-1:0][DATA_W-1:0] wr_data;
  logic                        init_busy;
  logic                        wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data, init_busy, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data,
    output rd_data, init_busy, wr_conflict
  );

endinterface
`default_nettype wire

// File: rtl/spu_regfile_mp_bypass.sv
`default_nettype none
// ============================================================================
//  Module   : spu_rf_bypass
//  Purpose  : One read port's forwarding network. Compares the read address
//             against every write port and, on a hit, returns the write data
//             of the highest-index matching enabled port instead of the
//             stored array data.
//  Ports    : rd_addr_i  - read address
//             wr_en_i    - write enables (already masked during clear)
//             wr_addr_i  - write addresses
//             wr_data_i  - write data
//             arr_data_i - stored array contents at rd_addr_i
//             rd_data_o  - resolved read data
//  Revision : 1.0 - initial release
// ============================================================================
module spu_rf_bypass
  import spu_rf_pkg::*;
#(
  parameter int DATA_W = QUADWORD,
  parameter int AW     = REG_ADDR_WIDTH,
  parameter int N_WR   = 2,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]                 rd_addr_i,
  input  logic [N_WR-1:0]               wr_en_i,
  input  logic [N_WR-1:0][AW-1:0]       wr_addr_i,
  input  logic [N_WR-1:0][DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W-1:0]             arr_data_i,
  output logic [DATA_W-1:0]             rd_data_o
);

  generate
    if (BYPASS != 0) begin : g_fwd
      // Later ports overwrite earlier hits, so the highest index wins,
      // matching the write priority of the array.
      always_comb begin
        rd_data_o = arr_data_i;
        for (int j = 0; j < N_WR; j++) begin
          if (wr_en_i[j] && (wr_addr_i[j] == rd_addr_i)) begin
            rd_data_o = wr_data_i[j];
          end
        end
      end
    end else begin : g_nofwd
      logic unused_ok;
      assign unused_ok = ^{rd_addr_i, wr_en_i, wr_addr_i, wr_data_i};
      assign rd_data_o = arr_data_i;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/spu_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : spu_regfile_mp
//  Purpose  : Parametrised multi-ported register file for the SPU datapath.
//             After reset the array is zeroed CLR_LANES rows per cycle; while
//             that runs, writes are dropped and reads return zero. In READY,
//             every enabled write port updates the array (highest index wins
//             on a shared address), reads are combinational with optional
//             same-cycle forwarding, and address collisions between enabled
//             write ports raise a one-cycle wr_conflict pulse.
//  Ports    : clk   - clock
//             reset - synchronous active-high reset
//             bus   - slave side of spu_regfile_mp_if (read/write ports,
//                     init_busy, wr_conflict)
//  Revision : 1.0 - initial release
// ============================================================================
module spu_regfile_mp
  import spu_rf_pkg::*;
#(
  parameter int DATA_W    = QUADWORD,
  parameter int DEPTH     = REG_COUNT,
  parameter int AW        = $clog2(DEPTH),
  parameter int N_RD      = 5,
  parameter int N_WR      = 2,
  parameter int CLR_LANES = 8,
  parameter int BYPASS    = 1
) (
  input  logic             clk,
  input  logic             reset,
  spu_regfile_mp_if.slave  bus
);

  // The step truncates to AW bits, so when CLR_LANES == DEPTH it is zero and
  // the pointer wrap coincides with the single clear edge.
  localparam logic [AW-1:0] C_CLR_STEP = AW'(CLR_LANES);
  localparam logic [AW-1:0] C_LAST_GRP = AW'(DEPTH - CLR_LANES);

  rf_state_t           state_q;
  logic [AW-1:0]       clr_ptr_q;
  logic                init_busy_q;
  logic                wr_conflict_q;
  logic                wr_conflict_d;
  logic [N_WR-1:0]     wr_en_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Writes are ignored outright while the clear sequence owns the array.
  always_comb begin
    wr_en_d = (state_q == READY) ? bus.wr_en : '0;
  end

  always_comb begin
    wr_conflict_d = 1'b0;
    for (int j = 0; j < N_WR; j++) begin
      for (int k = j + 1; k < N_WR; k++) begin
        if (wr_en_d[j] && wr_en_d[k] && (bus.wr_addr[j] == bus.wr_addr[k])) begin
          wr_conflict_d = 1'b1;
        end
      end
    end
  end

  // Clear/ready controller with registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= CLEAR;
      clr_ptr_q     <= '0;
      init_busy_q   <= 1'b1;
      wr_conflict_q <= 1'b0;
    end else begin
      wr_conflict_q <= wr_conflict_d;
      case (state_q)
        CLEAR: begin
          clr_ptr_q <= clr_ptr_q + C_CLR_STEP;
          if (clr_ptr_q == C_LAST_GRP) begin
            state_q     <= READY;
            init_busy_q <= 1'b0;
          end
        end
        READY: begin
          state_q <= READY;
        end
        default: begin
          state_q     <= CLEAR;
          clr_ptr_q   <= '0;
          init_busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Array update. The reset edge itself leaves the array untouched. Write
  // ports are visited in ascending order so the highest-index port's
  // non-blocking update lands last on a shared address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        for (int l = 0; l < CLR_LANES; l++) begin
          mem_q[clr_ptr_q + AW'(l)] <= '0;
        end
      end else begin
        for (int j = 0; j < N_WR; j++) begin
          if (wr_en_d[j]) begin
            mem_q[bus.wr_addr[j]] <= bus.wr_data[j];
          end
        end
      end
    end
  end

  assign bus.init_busy   = init_busy_q;
  assign bus.wr_conflict = wr_conflict_q;

  generate
    for (genvar i = 0; i < N_RD; i++) begin : g_rd
      logic [DATA_W-1:0] arr_data;
      logic [DATA_W-1:0] rd_data;

      // Zero during clear; the masked enables keep forwarding quiet as well.
      assign arr_data = (state_q == READY) ? mem_q[bus.rd_addr[i]] : '0;

      spu_rf_bypass #(
        .DATA_W (DATA_W),
        .AW     (AW),
        .N_WR   (N_WR),
        .BYPASS (BYPASS)
      ) u_bypass (
        .rd_addr_i  (bus.rd_addr[i]),
        .wr_en_i    (wr_en_d),
        .wr_addr_i  (bus.wr_addr),
        .wr_data_i  (bus.wr_data),
        .arr_data_i (arr_data),
        .rd_data_o  (rd_data)
      );

      assign bus.rd_data[i] = rd_data;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_spu_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spu_regfile_mp
//  Purpose  : Self-checking bench for spu_regfile_mp. Three instances:
//             u_dut0 default (BYPASS=1), u_dut1 BYPASS=0, u_dut2 with
//             DEPTH=32, CLR_LANES=32, N_RD=3, N_WR=3.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spu_regfile_mp;

  localparam logic [127:0] D5  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] DA  = {8{16'hAAAA}};
  localparam logic [127:0] D11 = {16{8'h11}};
  localparam logic [127:0] D22 = {16{8'h22}};
  localparam logic [127:0] DFF = {128{1'b1}};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spu_regfile_mp_if #(.DATA_W(128), .DEPTH(128), .N_RD(5), .N_WR(2)) if0 ();
  spu_regfile_mp_if #(.DATA_W(128), .DEPTH(128), .N_RD(5), .N_WR(2)) if1 ();
  spu_regfile_mp_if #(.DATA_W(128), .DEPTH(32),  .N_RD(3), .N_WR(3)) if2 ();

  spu_regfile_mp #(.DATA_W(128), .DEPTH(128), .N_RD(5), .N_WR(2),
                   .CLR_LANES(8), .BYPASS(1))
    u_dut0 (.clk(clk), .reset(reset), .bus(if0));
  spu_regfile_mp #(.DATA_W(128), .DEPTH(128), .N_RD(5), .N_WR(2),
                   .CLR_LANES(8), .BYPASS(0))
    u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  spu_regfile_mp #(.DATA_W(128), .DEPTH(32), .N_RD(3), .N_WR(3),
                   .CLR_LANES(32), .BYPASS(1))
    u_dut2 (.clk(clk), .reset(reset), .bus(if2));

  // kind: 0 = rd_data[idx], 1 = init_busy, 2 = wr_conflict
  typedef struct {
    int           dut;
    int           kind;
    int           idx;
    logic [127:0] exp;
    string        name;
  } chk_t;

  chk_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic expect_v(input int dut, input int kind, input int idx,
                          input logic [127:0] exp, input string name);
    chk_t c;
    c.dut = dut; c.kind = kind; c.idx = idx; c.exp = exp; c.name = name;
    sb.push_back(c);
  endtask

  function automatic logic [127:0] actual(input int dut, input int kind, input int idx);
    logic [127:0] v;
    v = '0;
    case (dut)
      0: case (kind)
           0: v = if0.rd_data[idx];
           1: v = {127'b0, if0.init_busy};
           default: v = {127'b0, if0.wr_conflict};
         endcase
      1: case (kind)
           0: v = if1.rd_data[idx];
           1: v = {127'b0, if1.init_busy};
           default: v = {127'b0, if1.wr_conflict};
         endcase
      default: case (kind)
           0: v = if2.rd_data[idx];
           1: v = {127'b0, if2.init_busy};
           default: v = {127'b0, if2.wr_conflict};
         endcase
    endcase
    return v;
  endfunction

  // Monitor: drains the scoreboard mid-cycle, away from the active edge.
  chk_t         mc;
  logic [127:0] ma;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mc = sb.pop_front();
      ma = actual(mc.dut, mc.kind, mc.idx);
      n_checks++;
      if (ma !== mc.exp) begin
        n_fail++;
        $display("FAIL %s (dut%0d idx%0d): got %h expected %h",
                 mc.name, mc.dut, mc.idx, ma, mc.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if0.wr_en = '0; if0.wr_addr = '0; if0.wr_data = '0; if0.rd_addr = '0;
    if1.wr_en = '0; if1.wr_addr = '0; if1.wr_data = '0; if1.rd_addr = '0;
    if2.wr_en = '0; if2.wr_addr = '0; if2.wr_data = '0; if2.rd_addr = '0;
  endtask

  // Same stimulus to the BYPASS=1 and BYPASS=0 instances.
  task automatic wr01(input int port, input int addr, input logic [127:0] d);
    if0.wr_en[port] = 1'b1; if0.wr_addr[port] = 7'(addr); if0.wr_data[port] = d;
    if1.wr_en[port] = 1'b1; if1.wr_addr[port] = 7'(addr); if1.wr_data[port] = d;
  endtask

  task automatic rd01(input int port, input int addr);
    if0.rd_addr[port] = 7'(addr);
    if1.rd_addr[port] = 7'(addr);
  endtask

  task automatic wr2(input int port, input int addr, input logic [127:0] d);
    if2.wr_en[port] = 1'b1; if2.wr_addr[port] = 5'(addr); if2.wr_data[port] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // ---------------- reset state and clear sequence ----------------
    expect_v(0, 2, 0, 0, "rst_conflict");
    expect_v(1, 2, 0, 0, "rst_conflict");
    expect_v(2, 1, 0, 1, "rst_busy_sweep");
    rd01(0, 77);
    for (int e = 1; e <= 16; e++) begin
      expect_v(0, 1, 0, 1, "clear_busy");
      expect_v(1, 1, 0, 1, "clear_busy");
      expect_v(0, 0, 0, 0, "rd_during_clear");
      if (e == 2) expect_v(2, 1, 0, 0, "sweep_clear_1edge");
      tick();
    end
    expect_v(0, 1, 0, 0, "busy_fall_16");
    expect_v(1, 1, 0, 0, "busy_fall_16");
    n_checks++;
    if (if0.init_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_fall_direct (dut0): got %b expected 0", if0.init_busy);
    end
    n_checks++;
    if (if1.init_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_fall_direct (dut1): got %b expected 0", if1.init_busy);
    end

    // every row reads zero after the clear
    for (int base = 0; base < 128; base += 5) begin
      for (int p = 0; p < 5; p++) begin
        if (base + p < 128) begin
          rd01(p, base + p);
          expect_v(0, 0, p, 0, "clear_row_zero");
          expect_v(1, 0, p, 0, "clear_row_zero");
        end
      end
      tick();
    end

    // ---------------- basic write/read ----------------
    idle_all();
    wr01(0, 5, D5); rd01(0, 5); rd01(1, 6);
    expect_v(0, 0, 0, D5, "wr5_bypass");
    expect_v(1, 0, 0, 0,  "wr5_nobypass_old");
    expect_v(0, 0, 1, 0,  "rd6_zero");
    tick();
    idle_all();
    rd01(0, 5); rd01(1, 6);
    expect_v(0, 0, 0, D5, "rd5_after_wr");
    expect_v(1, 0, 0, D5, "rd5_after_wr");
    expect_v(0, 0, 1, 0,  "rd6_zero");
    expect_v(1, 0, 1, 0,  "rd6_zero");
    #1;
    n_checks++;
    if (if1.rd_data[0] !== D5) begin
      n_fail++;
      $display("FAIL rd5_direct (dut1): got %h expected %h", if1.rd_data[0], D5);
    end
    tick();

    // ---------------- same-cycle forwarding ----------------
    idle_all();
    wr01(1, 10, DA); rd01(2, 10);
    expect_v(0, 0, 2, DA, "bypass_port1");
    expect_v(1, 0, 2, 0,  "nobypass_old");
    tick();
    idle_all();
    rd01(2, 10);
    expect_v(0, 0, 2, DA, "rd10_after_wr");
    expect_v(1, 0, 2, DA, "rd10_after_wr");
    tick();

    // ---------------- write conflicts ----------------
    idle_all();
    wr01(0, 3, D11); wr01(1, 3, D22); rd01(3, 3);
    expect_v(0, 0, 3, D22, "conflict_bypass_hi_port");
    expect_v(1, 0, 3, 0,   "conflict_nobypass_old");
    expect_v(0, 2, 0, 0,   "conflict_not_yet");
    tick();
    wr01(0, 3, D11); wr01(1, 3, D22);
    expect_v(0, 2, 0, 1,   "conflict_pulse");
    expect_v(1, 2, 0, 1,   "conflict_pulse");
    expect_v(1, 0, 3, D22, "conflict_row3");
    tick();
    idle_all();
    rd01(3, 3);
    expect_v(0, 2, 0, 1,   "conflict_back_to_back");
    expect_v(0, 0, 3, D22, "conflict_row3");
    expect_v(1, 0, 3, D22, "conflict_row3");
    tick();
    idle_all();
    wr01(0, 20, DA); wr01(1, 21, D11);
    expect_v(0, 2, 0, 0, "conflict_cleared");
    expect_v(1, 2, 0, 0, "conflict_cleared");
    tick();
    idle_all();
    rd01(0, 20); rd01(1, 21);
    expect_v(0, 2, 0, 0,   "no_conflict_diff_addr");
    expect_v(1, 0, 0, DA,  "dual_write_p0");
    expect_v(1, 0, 1, D11, "dual_write_p1");
    tick();

    // ---------------- reset mid-clear ----------------
    idle_all();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      wr01(0, 0, DFF); rd01(0, 0);
      expect_v(0, 1, 0, 1, "midclr_busy");
      expect_v(0, 0, 0, 0, "midclr_rd_zero");
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      wr01(0, 0, DFF);
      expect_v(0, 1, 0, 1, "restart_busy");
      expect_v(1, 1, 0, 1, "restart_busy");
      tick();
    end
    idle_all();
    rd01(0, 0); rd01(1, 5); rd01(2, 10);
    expect_v(0, 1, 0, 0, "restart_busy_fall");
    expect_v(0, 0, 0, 0, "dropped_write_row0");
    expect_v(1, 0, 0, 0, "dropped_write_row0");
    expect_v(0, 0, 1, 0, "recleared_row5");
    expect_v(1, 0, 2, 0, "recleared_row10");
    expect_v(0, 2, 0, 0, "no_conflict_in_clear");
    tick();

    // ---------------- parameter sweep instance ----------------
    idle_all();
    wr2(0, 7, D11); wr2(1, 7, D22); wr2(2, 7, DA);
    if2.rd_addr[0] = 5'd7;
    expect_v(2, 1, 0, 0,  "sweep_ready");
    expect_v(2, 0, 0, DA, "sweep_bypass_p2");
    expect_v(2, 2, 0, 0,  "sweep_conflict_not_yet");
    tick();
    idle_all();
    wr2(1, 31, D5);
    if2.rd_addr[0] = 5'd7; if2.rd_addr[1] = 5'd31; if2.rd_addr[2] = 5'd0;
    expect_v(2, 2, 0, 1,  "sweep_conflict");
    expect_v(2, 0, 0, DA, "sweep_row7_p2_wins");
    expect_v(2, 0, 1, D5, "sweep_bypass_row31");
    expect_v(2, 0, 2, 0,  "sweep_row0_zero");
    n_checks++;
    if (if2.wr_conflict !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_conflict_direct (dut2): got %b expected 1", if2.wr_conflict);
    end
    tick();
    idle_all();
    if2.rd_addr[1] = 5'd31;
    expect_v(2, 2, 0, 0,  "sweep_conflict_clear");
    expect_v(2, 0, 1, D5, "sweep_row31");
    tick();

    @(negedge clk);
    #1;
    if (n_fail == 0 && n_checks >= 12)
      $display("PASS");
    else
      $display("FAIL summary: got %0d failures over %0d checks expected 0 failures", n_fail, n_checks);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spu_regfile_mp.md
# spu_regfile_mp

Parametrised multi-ported register file for the SPU datapath, generalising the fixed 5-read/2-write file to configurable width, depth, and read/write port counts. It adds three things: a sequenced hardware clear after reset, same-cycle write-to-read bypass, and write-port conflict detection. It sits between the decode/issue stage (read addresses) and the even/odd writeback stages (write ports).

## Interface
Parameters:
- DATA_W, default 128 (QUADWORD): register width in bits.
- DEPTH, default 128 (REG_COUNT): number of registers. Power of two.
- AW, default $clog2(DEPTH) (REG_ADDR_WIDTH = 7): address width.
- N_RD, default 5: read port count.
- N_WR, default 2: write port count. Port 0 = even pipe, port 1 = odd pipe.
- CLR_LANES, default 8: registers zeroed per clear cycle. Power of two, must divide DEPTH.
- BYPASS, default 1: 1 = a same-cycle write is forwarded to matching reads; 0 = reads return stored contents only.

Ports:
- clk  in  1  clock. All state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- rd_addr[N_RD]  in  AW  read addresses.
- rd_data[N_RD]  out  DATA_W  read data. Combinational from rd_addr and the write ports.
- wr_en[N_WR]  in  1  write enables.
- wr_addr[N_WR]  in  AW  write addresses.
- wr_data[N_WR]  in  DATA_W  write data.
- init_busy  out  1  high while reset or the clear sequence is in progress. Reset value 1.
- wr_conflict  out  1  registered one-cycle pulse: two or more enabled write ports targeted the same address on the previous edge. Reset value 0.

## Operation
- FSM states: CLEAR, READY.
- reset=1 at an edge: state←CLEAR, clr_ptr←0, wr_conflict←0. No array write occurs on that edge.
- CLEAR with reset=0: each edge zeroes rows clr_ptr … clr_ptr+CLR_LANES−1, then clr_ptr += CLR_LANES. On the edge that clears the last group, state←READY.
- reset reasserted mid-clear: the sequence restarts from row 0.
- init_busy = (state==CLEAR).
- While init_busy=1:
  - wr_en is ignored (writes dropped, no conflict flagged).
  - All rd_data read 0.
- READY: on each edge, every port with wr_en=1 writes wr_data to wr_addr.
  - Same-address conflict: the highest-index enabled port wins.
  - wr_conflict is set on the next edge if any pair of enabled ports had equal addresses; otherwise it is cleared.
- Reads in READY:
  - BYPASS=1: rd_data[i] = wr_data[j] of the highest-index enabled port j with wr_addr[j]==rd_addr[i]; otherwise the array contents.
  - BYPASS=0: array contents only.
- Register 0 is not special: it is writable and readable like any other.
- No arithmetic beyond the clr_ptr increment. clr_ptr is AW bits wide; its wrap to 0 coincides with the transition to READY.

## Timing
- Read latency: 0 cycles (combinational). Write latency: data is visible in the array after 1 edge; with BYPASS=1 it is visible in the same cycle.
- Clear duration: DEPTH/CLR_LANES edges with reset=0. Defaults: 16 edges. init_busy falls after the 16th edge.
- The first accepted write is on the edge following the fall of init_busy.
- wr_conflict asserts 1 cycle after the conflicting edge and lasts 1 cycle per conflicting edge. Back-to-back conflicts hold it high.

## Structure
- Package spu_rf_pkg holds:
  - constants QUADWORD=128, REG_ADDR_WIDTH=7, REG_COUNT=128;
  - typedef rf_state_t enum {CLEAR, READY}.
- Sub-module spu_rf_bypass, instantiated once per read port: N_WR-way address compare plus priority mux selecting between write data and array data. The top level keeps the array, clear FSM, write logic and conflict detection.

## Test plan
- Reset 1 cycle, then idle: init_busy=1 for exactly 16 edges then 0; all 128 rows read 0; reads during clear return 0.
- After clear: write port0 addr 5 = 0x0123…EF. Next cycle, rd_addr[0]=5 returns that value and rd_addr[1]=6 returns 0.
- Bypass, BYPASS=1: port1 writes addr 10 = 0xAAAA… while rd_addr[2]=10 in the same cycle; rd_data[2]=0xAAAA… combinationally. With BYPASS=0, the same stimulus returns the old value (0).
- Conflict: port0 writes addr 3 = 0x11…, port1 writes addr 3 = 0x22… on the same edge. Row 3 = 0x22…, and wr_conflict=1 for exactly the next cycle.
- Reset mid-clear: assert reset at clear edge 9. Clear restarts; init_busy stays high 16 edges after release. A write with wr_en=1 to addr 0 = 0xFF… issued during clear is dropped, and row 0 reads 0 afterwards.
- Parameter sweep: DEPTH=32, CLR_LANES=32, N_RD=3, N_WR=3. Clear takes 1 edge. A three-way write to addr 7 keeps port2's data and raises wr_conflict.
